ym_io_queue: RTL and testbench
==============================

YM_IO_QUEUE -- requirements
Module: ym_io_queue

Interface
REQ-001 SHALL have parameter NPORT, default 2, meaning the number of address/data register ports (1..4).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the write-queue entry count (power of two, 2..16).
REQ-003 SHALL have parameter BUSY_CYC, default 32, meaning core cycles between successive register writes (2..255).
REQ-004 SHALL define PW = max(1, clog2(NPORT)) and AW = PW+1.
REQ-005 SHALL have port MCLK  in  1  the single clock; all state on rising edge.
REQ-006 SHALL have port IC  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cyc_en  in  1  one-MCLK pulse marking a core-cycle boundary.
REQ-008 SHALL have ports CS, WR, RD  in  1 each  active-low host bus strobes, asynchronous to MCLK.
REQ-009 SHALL have port address  in  AW  host address: bit0 = 0 address / 1 data; bits AW-1:1 = port index.
REQ-010 SHALL have port data  in  8  host write data.
REQ-011 SHALL have port data_bus  out  8  status read data; data_oe  out  1  read drive enable.
REQ-012 SHALL have ports reg_we  out  1, reg_port  out  PW, reg_addr  out  8, reg_data  out  8: core register write, valid for one MCLK when reg_we=1.

Function
REQ-013 SHALL pass CS, WR, RD, address, data through a 2-flop MCLK synchroniser; wr_s = ~WR_s & ~CS_s, rd_s = ~RD_s & ~CS_s.
REQ-014 SHALL accept a host write only on the 0->1 transition of wr_s, using the synchronised address/data of that cycle (3 MCLK pin-to-action latency).
REQ-015 SHALL, on an accepted address write, load addr_reg[port] with data; other ports unchanged.
REQ-016 SHALL, on an accepted data write, push {port, addr_reg[port], data} to the queue; addr_reg is retained.
REQ-017 SHALL ignore accepted writes whose port index >= NPORT.
REQ-018 SHALL, on a push while full with no pop that cycle, drop the entry and set sticky ovf.
REQ-019 SHALL accept a push to a full queue when a pop occurs in the same cycle.
REQ-020 SHALL hold busy_cnt (8 bits), decremented on each cyc_en while nonzero.
REQ-021 SHALL pop on cyc_en when busy_cnt==0 and queue nonempty: reg_we=1 that cycle with the entry on reg_port/reg_addr/reg_data, and busy_cnt loaded BUSY_CYC-1; pops are thus spaced exactly BUSY_CYC cyc_en pulses.
REQ-022 SHALL drive reg_we=0 and hold reg_port/reg_addr/reg_data at last values when not popping.
REQ-023 SHALL compute status = {busy, full, ovf, 5'b0}, busy = (busy_cnt!=0) | nonempty.
REQ-024 SHALL register status into data_bus on the 0->1 transition of rd_s and clear ovf in the same cycle (unless set again that cycle, where set wins).
REQ-025 SHALL drive data_oe = rd_s.
REQ-026 SHALL preserve FIFO order; pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-027 SHALL, while IC=0, asynchronously clear synchronisers, addr_reg[*], queue pointers/count, busy_cnt, ovf, data_bus, reg_port/reg_addr/reg_data to 0; reg_we=0, data_oe=0.
REQ-028 SHALL discard queued entries on reset mid-operation; no reg_we until a new data write after IC=1.

Structure
REQ-029 SHALL place PW/AW computation, status bit positions, and queue entry field widths in shared package ym_io_pkg.
REQ-030 SHALL implement the queue as sub-module ym_io_fifo (synchronous, width PW+16, push/pop/full/empty/count).

Verification
REQ-031 Addr write 0x28 port0, data write 0xF0 -> one reg_we with port0/0x28/0xF0 at next cyc_en with busy_cnt==0.
REQ-032 Four back-to-back data writes, defaults -> four reg_we pulses exactly 32 cyc_en apart, busy=1 until 31 cyc_en after last.
REQ-033 Six data writes, no cyc_en -> queue full after 4, ovf=1; status read returns 0xE0, next read 0xC0.
REQ-034 Addr 0x30 to port1 then data to port0 and port1 -> reg_addr uses each port's own latch (0 and 0x30).
REQ-035 Push to full queue on popping cyc_en -> entry accepted, ovf stays 0, count unchanged.
REQ-036 IC pulsed low with 3 queued entries -> all outputs 0 immediately, no reg_we after release.

Source files
------------

// File: rtl/ym_io_pkg.sv
// ym_io_pkg: shared widths, status bit positions and
// entry layout for the host register write queue.
package ym_io_pkg;

  localparam int REG_AW = 8;
  localparam int REG_DW = 8;

  localparam int ST_BUSY = 7;
  localparam int ST_FULL = 6;
  localparam int ST_OVF  = 5;

  function automatic int calc_pw(input int nport);
    return (nport <= 1) ? 1 : $clog2(nport);
  endfunction

  function automatic int calc_aw(input int nport);
    return calc_pw(nport) + 1;
  endfunction

  function automatic int entry_w(input int nport);
    return calc_pw(nport) + REG_AW + REG_DW;
  endfunction

endpackage

// File: rtl/ym_io_fifo.sv
// ym_io_fifo: synchronous show-ahead FIFO; a push to a
// full queue is taken when a pop happens that same cycle.
module ym_io_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTRW = $clog2(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PTRW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // entry storage, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ym_io_queue.sv
// ym_io_queue: host bus front end that latches register
// addresses and paces queued register writes to the core.
module ym_io_queue
  import ym_io_pkg::*;
#(
  parameter int NPORT    = 2,
  parameter int DEPTH    = 4,
  parameter int BUSY_CYC = 32
) (
  input  logic                        MCLK,
  input  logic                        IC,
  input  logic                        cyc_en,
  input  logic                        CS,
  input  logic                        WR,
  input  logic                        RD,
  input  logic [calc_aw(NPORT)-1:0]   address,
  input  logic [7:0]                  data,
  output logic [7:0]                  data_bus,
  output logic                        data_oe,
  output logic                        reg_we,
  output logic [calc_pw(NPORT)-1:0]   reg_port,
  output logic [REG_AW-1:0]           reg_addr,
  output logic [REG_DW-1:0]           reg_data
);

  localparam int PW = calc_pw(NPORT);
  localparam int AW = calc_aw(NPORT);
  localparam int EW = entry_w(NPORT);
  localparam int CW = $clog2(DEPTH) + 1;

  // strobes are kept active-high so a cleared
  // synchroniser reads as an idle bus
  logic [2:0]    strb_m, strb_s;
  logic [AW-1:0] addr_m, addr_s;
  logic [7:0]    data_m, data_s;
  logic          wr_q, rd_q;
  logic          wr_s, rd_s;
  logic          wr_acc, rd_acc;

  logic [PW-1:0] idx;
  logic          idx_ok;
  logic [7:0]    addr_reg [NPORT];
  logic [7:0]    cur_addr;

  logic          push_req;
  logic          pop;
  logic [EW-1:0] q_wdata, q_rdata;
  logic          q_full, q_empty;
  logic [CW-1:0] q_count;

  logic [7:0]    busy_cnt;
  logic          busy;
  logic          ovf;
  logic          ovf_set;
  logic [7:0]    status;

  logic [PW-1:0] hold_port;
  logic [7:0]    hold_addr;
  logic [7:0]    hold_data;

  assign wr_s   = strb_s[2] & strb_s[1];
  assign rd_s   = strb_s[2] & strb_s[0];
  assign wr_acc = wr_s & ~wr_q;
  assign rd_acc = rd_s & ~rd_q;
  assign data_oe = rd_s;

  assign idx    = addr_s[AW-1:1];
  assign idx_ok = ({{(32-PW){1'b0}}, idx} < 32'(NPORT));

  assign push_req = wr_acc & addr_s[0] & idx_ok;
  assign pop      = cyc_en & (busy_cnt == 8'd0) & ~q_empty;
  assign ovf_set  = push_req & q_full & ~pop;
  assign q_wdata  = {idx, cur_addr, data_s};

  assign busy = (busy_cnt != 8'd0) | (q_count != '0);

  // two-flop synchroniser plus edge-detect history
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      strb_m <= '0;
      strb_s <= '0;
      addr_m <= '0;
      addr_s <= '0;
      data_m <= '0;
      data_s <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      strb_m <= {~CS, ~WR, ~RD};
      strb_s <= strb_m;
      addr_m <= address;
      addr_s <= addr_m;
      data_m <= data;
      data_s <= data_m;
      wr_q   <= wr_s;
      rd_q   <= rd_s;
    end
  end

  // per-port register address latches
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      for (int p = 0; p < NPORT; p++)
        addr_reg[p] <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++)
        if (wr_acc && !addr_s[0] && idx_ok
            && idx == PW'(p))
          addr_reg[p] <= data_s;
    end
  end

  // address latch of the port being written
  always_comb begin
    cur_addr = '0;
    for (int p = 0; p < NPORT; p++)
      if (idx == PW'(p)) cur_addr = addr_reg[p];
  end

  ym_io_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (MCLK),
    .rst_n (IC),
    .push  (push_req),
    .pop   (pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // write pacing counter, reloaded on every pop
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC)
      busy_cnt <= '0;
    else if (pop)
      busy_cnt <= 8'(BUSY_CYC - 1);
    else if (cyc_en && busy_cnt != 8'd0)
      busy_cnt <= busy_cnt - 8'd1;
  end

  // status word assembly
  always_comb begin
    status          = '0;
    status[ST_BUSY] = busy;
    status[ST_FULL] = q_full;
    status[ST_OVF]  = ovf;
  end

  // sticky overflow and status read register
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      ovf      <= 1'b0;
      data_bus <= '0;
    end else begin
      if (rd_acc) data_bus <= status;
      if (ovf_set)     ovf <= 1'b1;
      else if (rd_acc) ovf <= 1'b0;
    end
  end

  // last popped entry, held between pops
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      hold_port <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (pop) begin
      hold_port <= q_rdata[EW-1:16];
      hold_addr <= q_rdata[15:8];
      hold_data <= q_rdata[7:0];
    end
  end

  // core write port shows the head during a pop
  always_comb begin
    reg_we   = pop;
    reg_port = hold_port;
    reg_addr = hold_addr;
    reg_data = hold_data;
    if (pop) begin
      reg_port = q_rdata[EW-1:16];
      reg_addr = q_rdata[15:8];
      reg_data = q_rdata[7:0];
    end
  end

endmodule

// File: tb/tb_ym_io_queue.sv
// tb_ym_io_queue: directed vectors for the host write
// queue with hand-computed expectations.
module tb_ym_io_queue;

  localparam int NPORT    = 2;
  localparam int DEPTH    = 4;
  localparam int BUSY_CYC = 32;
  localparam int PW       = 1;
  localparam int AW       = 2;

  logic          MCLK = 1'b0;
  logic          IC = 1'b0;
  logic          cyc_en = 1'b0;
  logic          CS = 1'b1;
  logic          WR = 1'b1;
  logic          RD = 1'b1;
  logic [AW-1:0] address = '0;
  logic [7:0]    data = '0;
  logic [7:0]    data_bus;
  logic          data_oe;
  logic          reg_we;
  logic [PW-1:0] reg_port;
  logic [7:0]    reg_addr;
  logic [7:0]    reg_data;

  int nvec = 0;
  int nerr = 0;

  int            npop;
  int            pop_idx  [8];
  logic [PW-1:0] pop_port [8];
  logic [7:0]    pop_addr [8];
  logic [7:0]    pop_data [8];

  logic          s_we;
  logic [PW-1:0] s_port;
  logic [7:0]    s_addr, s_data, rv;

  ym_io_queue #(
    .NPORT    (NPORT),
    .DEPTH    (DEPTH),
    .BUSY_CYC (BUSY_CYC)
  ) dut (
    .MCLK     (MCLK),
    .IC       (IC),
    .cyc_en   (cyc_en),
    .CS       (CS),
    .WR       (WR),
    .RD       (RD),
    .address  (address),
    .data     (data),
    .data_bus (data_bus),
    .data_oe  (data_oe),
    .reg_we   (reg_we),
    .reg_port (reg_port),
    .reg_addr (reg_addr),
    .reg_data (reg_data)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input logic [AW-1:0] a,
                         input logic [7:0] d);
    @(negedge MCLK);
    address = a;
    data = d;
    CS = 1'b0;
    WR = 1'b0;
    repeat (4) @(negedge MCLK);
    WR = 1'b1;
    CS = 1'b1;
    repeat (4) @(negedge MCLK);
  endtask

  task automatic host_rd(output logic [7:0] v);
    @(negedge MCLK);
    CS = 1'b0;
    RD = 1'b0;
    repeat (4) @(negedge MCLK);
    chk("data_oe", data_oe, 1);
    v = data_bus;
    CS = 1'b1;
    RD = 1'b1;
    repeat (4) @(negedge MCLK);
  endtask

  task automatic pulse(output logic we,
                       output logic [PW-1:0] p,
                       output logic [7:0] a,
                       output logic [7:0] d);
    @(negedge MCLK);
    cyc_en = 1'b1;
    #1;
    we = reg_we;
    p = reg_port;
    a = reg_addr;
    d = reg_data;
    @(negedge MCLK);
    cyc_en = 1'b0;
  endtask

  task automatic run(input int n);
    logic          we;
    logic [PW-1:0] p;
    logic [7:0]    a, d;
    npop = 0;
    for (int i = 0; i < n; i++) begin
      pulse(we, p, a, d);
      if (we) begin
        if (npop < 8) begin
          pop_idx[npop]  = i;
          pop_port[npop] = p;
          pop_addr[npop] = a;
          pop_data[npop] = d;
        end
        npop++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge MCLK);
    IC = 1'b0;
    repeat (2) @(negedge MCLK);
    IC = 1'b1;
    repeat (2) @(negedge MCLK);
  endtask

  initial begin
    repeat (3) @(negedge MCLK);
    chk("rst data_bus", data_bus, 8'h00);
    chk("rst data_oe",  data_oe,  0);
    chk("rst reg_we",   reg_we,   0);
    chk("rst reg_addr", reg_addr, 8'h00);
    IC = 1'b1;
    repeat (2) @(negedge MCLK);
    host_rd(rv);
    chk("rst status", rv, 8'h00);

    // single address then data write
    host_wr(2'b00, 8'h28);
    host_wr(2'b01, 8'hF0);
    host_rd(rv);
    chk("one status", rv, 8'h80);
    pulse(s_we, s_port, s_addr, s_data);
    chk("one we",   s_we,   1);
    chk("one port", s_port, 0);
    chk("one addr", s_addr, 8'h28);
    chk("one data", s_data, 8'hF0);
    pulse(s_we, s_port, s_addr, s_data);
    chk("hold we",   s_we,   0);
    chk("hold addr", s_addr, 8'h28);
    chk("hold data", s_data, 8'hF0);
    run(29);
    chk("one nopop", npop, 0);
    host_rd(rv);
    chk("one cnt1", rv, 8'h80);
    run(1);
    host_rd(rv);
    chk("one idle", rv, 8'h00);

    // four back-to-back writes, pacing
    for (int i = 1; i <= 4; i++)
      host_wr(2'b01, 8'(i));
    run(127);
    chk("pace npop", npop, 4);
    for (int i = 0; i < 4; i++) begin
      chk("pace idx",  pop_idx[i],  32 * i);
      chk("pace data", pop_data[i], i + 1);
      chk("pace addr", pop_addr[i], 8'h28);
    end
    host_rd(rv);
    chk("pace busy", rv, 8'h80);
    run(1);
    host_rd(rv);
    chk("pace idle", rv, 8'h00);

    // overflow with no cyc_en
    for (int i = 0; i < 6; i++)
      host_wr(2'b01, 8'(8'h10 + i));
    host_rd(rv);
    chk("ovf rd1", rv, 8'hE0);
    host_rd(rv);
    chk("ovf rd2", rv, 8'hC0);
    run(128);
    chk("ovf npop", npop, 4);
    for (int i = 0; i < 4; i++)
      chk("ovf data", pop_data[i], 8'h10 + i);
    host_rd(rv);
    chk("ovf idle", rv, 8'h00);

    // per-port address latches
    do_reset();
    host_wr(2'b10, 8'h30);
    host_wr(2'b01, 8'hA1);
    host_wr(2'b11, 8'hB2);
    run(64);
    chk("port npop", npop, 2);
    chk("p0 port", pop_port[0], 0);
    chk("p0 addr", pop_addr[0], 8'h00);
    chk("p0 data", pop_data[0], 8'hA1);
    chk("p1 port", pop_port[1], 1);
    chk("p1 addr", pop_addr[1], 8'h30);
    chk("p1 data", pop_data[1], 8'hB2);
    chk("p1 idx",  pop_idx[1],  32);
    host_rd(rv);
    chk("port idle", rv, 8'h00);

    // push into full queue on a popping cyc_en
    for (int i = 0; i < 4; i++)
      host_wr(2'b01, 8'(8'h21 + i));
    host_rd(rv);
    chk("fp full", rv, 8'hC0);
    @(negedge MCLK);
    address = 2'b01;
    data = 8'h25;
    CS = 1'b0;
    WR = 1'b0;
    @(negedge MCLK);
    @(negedge MCLK);
    cyc_en = 1'b1;
    #1;
    chk("fp we",   reg_we,   1);
    chk("fp data", reg_data, 8'h21);
    @(negedge MCLK);
    cyc_en = 1'b0;
    CS = 1'b1;
    WR = 1'b1;
    repeat (4) @(negedge MCLK);
    host_rd(rv);
    chk("fp noovf", rv, 8'hC0);
    run(128);
    chk("fp npop", npop, 4);
    for (int i = 0; i < 4; i++)
      chk("fp order", pop_data[i], 8'h22 + i);

    // reset with queued entries
    for (int i = 0; i < 3; i++)
      host_wr(2'b01, 8'(8'h31 + i));
    host_rd(rv);
    chk("rq status", rv, 8'h80);
    @(negedge MCLK);
    IC = 1'b0;
    #1;
    chk("rq data_bus", data_bus, 8'h00);
    chk("rq reg_we",   reg_we,   0);
    chk("rq reg_port", reg_port, 0);
    chk("rq reg_addr", reg_addr, 8'h00);
    chk("rq reg_data", reg_data, 8'h00);
    chk("rq data_oe",  data_oe,  0);
    @(negedge MCLK);
    IC = 1'b1;
    run(40);
    chk("rq npop", npop, 0);
    host_rd(rv);
    chk("rq idle", rv, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
